// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between the fetch (I) and load/store (D) ports.
// One transaction in flight, D preferred with a starvation cap for I, and a watchdog on m_ack.
module mem_port_arbiter #(
    parameter int AW           = 13,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_ready,
    output logic          i_err,

    input  logic          d_req,
    input  logic          d_we,
    input  logic [3:0]    d_be,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic          d_err,

    output logic          m_req,
    output logic          m_we,
    output logic [3:0]    m_be,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ack,

    output logic          busy
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam int WW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIMIT);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [CW-1:0] r_cnt;
    logic [WW-1:0] r_wd;
    logic          r_m_req;
    logic          r_m_we;
    logic [3:0]    r_m_be;
    logic [AW-1:0] r_m_addr;
    logic [DW-1:0] r_m_wdata;
    logic [DW-1:0] r_i_rdata;
    logic [DW-1:0] r_d_rdata;
    logic          r_i_ready;
    logic          r_i_err;
    logic          r_d_ready;
    logic          r_d_err;
    logic          r_busy;

    logic [CW-1:0] w_cnt_nxt;
    logic [WW-1:0] w_wd_nxt;
    logic          w_m_req_nxt;
    logic          w_m_we_nxt;
    logic [3:0]    w_m_be_nxt;
    logic [AW-1:0] w_m_addr_nxt;
    logic [DW-1:0] w_m_wdata_nxt;
    logic [DW-1:0] w_i_rdata_nxt;
    logic [DW-1:0] w_d_rdata_nxt;
    logic          w_i_ready_nxt;
    logic          w_i_err_nxt;
    logic          w_d_ready_nxt;
    logic          w_d_err_nxt;

    logic          w_i_elig;
    logic          w_d_elig;
    logic          w_grant_d;
    logic          w_grant_i;
    logic          w_expire;

    // A port whose ready is pulsing this cycle is still showing the old request; skip it.
    assign w_i_elig  = i_req & ~r_i_ready;
    assign w_d_elig  = d_req & ~r_d_ready;
    assign w_grant_d = (r_state == ST_IDLE) && w_d_elig && !(w_i_elig && (r_cnt == CNT_MAX));
    assign w_grant_i = (r_state == ST_IDLE) && w_i_elig && !w_grant_d;
    assign w_expire  = !m_ack && (r_wd == WD_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_d) begin
                    w_state_nxt = ST_BUSY_D;
                end else if (w_grant_i) begin
                    w_state_nxt = ST_BUSY_I;
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                if (m_ack || w_expire) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_nxt     = r_cnt;
        w_wd_nxt      = r_wd;
        w_m_req_nxt   = r_m_req;
        w_m_we_nxt    = r_m_we;
        w_m_be_nxt    = r_m_be;
        w_m_addr_nxt  = r_m_addr;
        w_m_wdata_nxt = r_m_wdata;
        w_i_rdata_nxt = r_i_rdata;
        w_d_rdata_nxt = r_d_rdata;
        w_i_ready_nxt = 1'b0;
        w_i_err_nxt   = 1'b0;
        w_d_ready_nxt = 1'b0;
        w_d_err_nxt   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_grant_d) begin
                    w_m_req_nxt   = 1'b1;
                    w_m_we_nxt    = d_we;
                    w_m_be_nxt    = d_be;
                    w_m_addr_nxt  = d_addr;
                    w_m_wdata_nxt = d_wdata;
                    w_wd_nxt      = '0;
                    if (w_i_elig) begin
                        w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
                    end else begin
                        w_cnt_nxt = '0;
                    end
                end else if (w_grant_i) begin
                    w_m_req_nxt   = 1'b1;
                    w_m_we_nxt    = 1'b0;
                    w_m_be_nxt    = 4'hF;
                    w_m_addr_nxt  = i_addr;
                    w_m_wdata_nxt = '0;
                    w_wd_nxt      = '0;
                    w_cnt_nxt     = '0;
                end
            end

            ST_BUSY_I: begin
                if (m_ack) begin
                    w_m_req_nxt   = 1'b0;
                    w_i_ready_nxt = 1'b1;
                    w_i_rdata_nxt = m_rdata;
                end else if (w_expire) begin
                    w_m_req_nxt   = 1'b0;
                    w_i_ready_nxt = 1'b1;
                    w_i_err_nxt   = 1'b1;
                    w_i_rdata_nxt = '0;
                end else begin
                    w_wd_nxt = r_wd + 1'b1;
                end
            end

            ST_BUSY_D: begin
                if (m_ack) begin
                    w_m_req_nxt   = 1'b0;
                    w_d_ready_nxt = 1'b1;
                    if (!r_m_we) begin
                        w_d_rdata_nxt = m_rdata;
                    end
                end else if (w_expire) begin
                    w_m_req_nxt   = 1'b0;
                    w_d_ready_nxt = 1'b1;
                    w_d_err_nxt   = 1'b1;
                    w_d_rdata_nxt = '0;
                end else begin
                    w_wd_nxt = r_wd + 1'b1;
                end
            end

            default: begin
                w_m_req_nxt = 1'b0;
            end
        endcase
    end

    // Reset mid-transaction drops everything silently; a late m_ack then lands in IDLE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_wd      <= '0;
            r_m_req   <= 1'b0;
            r_m_we    <= 1'b0;
            r_m_be    <= '0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
            r_i_ready <= 1'b0;
            r_i_err   <= 1'b0;
            r_d_ready <= 1'b0;
            r_d_err   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_wd      <= w_wd_nxt;
            r_m_req   <= w_m_req_nxt;
            r_m_we    <= w_m_we_nxt;
            r_m_be    <= w_m_be_nxt;
            r_m_addr  <= w_m_addr_nxt;
            r_m_wdata <= w_m_wdata_nxt;
            r_i_rdata <= w_i_rdata_nxt;
            r_d_rdata <= w_d_rdata_nxt;
            r_i_ready <= w_i_ready_nxt;
            r_i_err   <= w_i_err_nxt;
            r_d_ready <= w_d_ready_nxt;
            r_d_err   <= w_d_err_nxt;
            r_busy    <= (w_state_nxt != ST_IDLE);
        end
    end

    assign i_rdata = r_i_rdata;
    assign i_ready = r_i_ready;
    assign i_err   = r_i_err;
    assign d_rdata = r_d_rdata;
    assign d_ready = r_d_ready;
    assign d_err   = r_d_err;
    assign m_req   = r_m_req;
    assign m_we    = r_m_we;
    assign m_be    = r_m_be;
    assign m_addr  = r_m_addr;
    assign m_wdata = r_m_wdata;
    assign busy    = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int AW           = 13;
    localparam int DW           = 32;
    localparam int STARVE_LIMIT = 4;
    localparam int TIMEOUT      = 16;

    logic          clk;
    logic          reset;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_ready;
    logic          i_err;
    logic          d_req;
    logic          d_we;
    logic [3:0]    d_be;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ready;
    logic          d_err;
    logic          m_req;
    logic          m_we;
    logic [3:0]    m_be;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          m_ack;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready), .d_err(d_err),
        .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: who owns the memory, how long it has waited, how many D wins
    // in a row happened while I was asking, and the expected visible outputs.
    int            mdl_owner;   // 0 none, 1 I, 2 D
    int            mdl_waited;
    int            mdl_streak;
    logic          mdl_m_req, mdl_m_we;
    logic [3:0]    mdl_m_be;
    logic [AW-1:0] mdl_m_addr;
    logic [DW-1:0] mdl_m_wdata, mdl_i_rdata, mdl_d_rdata;
    logic          mdl_i_ready, mdl_i_err, mdl_d_ready, mdl_d_err;

    task automatic model_reset();
        mdl_owner   = 0;
        mdl_waited  = 0;
        mdl_streak  = 0;
        mdl_m_req   = 1'b0;
        mdl_m_we    = 1'b0;
        mdl_m_be    = '0;
        mdl_m_addr  = '0;
        mdl_m_wdata = '0;
        mdl_i_rdata = '0;
        mdl_d_rdata = '0;
        mdl_i_ready = 1'b0;
        mdl_i_err   = 1'b0;
        mdl_d_ready = 1'b0;
        mdl_d_err   = 1'b0;
    endtask

    task automatic finish_txn(input logic err, input logic [DW-1:0] data);
        if (mdl_owner == 1) begin
            mdl_i_ready = 1'b1;
            mdl_i_err   = err;
            mdl_i_rdata = data;
        end else begin
            mdl_d_ready = 1'b1;
            mdl_d_err   = err;
            if (err || !mdl_m_we) mdl_d_rdata = data;
        end
        mdl_m_req = 1'b0;
        mdl_owner = 0;
    endtask

    task automatic model_step();
        logic i_ok, d_ok;
        if (!reset) begin
            model_reset();
            return;
        end
        i_ok = i_req && !mdl_i_ready;
        d_ok = d_req && !mdl_d_ready;
        mdl_i_ready = 1'b0;
        mdl_i_err   = 1'b0;
        mdl_d_ready = 1'b0;
        mdl_d_err   = 1'b0;
        if (mdl_owner == 0) begin
            if (d_ok && !(i_ok && mdl_streak >= STARVE_LIMIT)) begin
                mdl_owner   = 2;
                mdl_m_we    = d_we;
                mdl_m_be    = d_be;
                mdl_m_addr  = d_addr;
                mdl_m_wdata = d_wdata;
                mdl_streak  = i_ok ? ((mdl_streak < STARVE_LIMIT) ? mdl_streak + 1 : mdl_streak) : 0;
            end else if (i_ok) begin
                mdl_owner   = 1;
                mdl_m_we    = 1'b0;
                mdl_m_be    = 4'hF;
                mdl_m_addr  = i_addr;
                mdl_m_wdata = '0;
                mdl_streak  = 0;
            end
            if (mdl_owner != 0) begin
                mdl_m_req  = 1'b1;
                mdl_waited = 1;
            end
        end else if (m_ack) begin
            finish_txn(1'b0, m_rdata);
        end else if (mdl_waited == TIMEOUT) begin
            finish_txn(1'b1, '0);
        end else begin
            mdl_waited++;
        end
    endtask

    task automatic compare_all();
        check("busy",    64'(busy),    64'(mdl_owner != 0));
        check("m_req",   64'(m_req),   64'(mdl_m_req));
        check("m_we",    64'(m_we),    64'(mdl_m_we));
        check("m_be",    64'(m_be),    64'(mdl_m_be));
        check("m_addr",  64'(m_addr),  64'(mdl_m_addr));
        check("m_wdata", 64'(m_wdata), 64'(mdl_m_wdata));
        check("i_ready", 64'(i_ready), 64'(mdl_i_ready));
        check("i_err",   64'(i_err),   64'(mdl_i_err));
        check("i_rdata", 64'(i_rdata), 64'(mdl_i_rdata));
        check("d_ready", 64'(d_ready), 64'(mdl_d_ready));
        check("d_err",   64'(d_err),   64'(mdl_d_err));
        check("d_rdata", 64'(d_rdata), 64'(mdl_d_rdata));
    endtask

    // One clock: model advances on the same edge, outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic settle(input int n);
        i_req = 1'b0;
        d_req = 1'b0;
        m_ack = 1'b1;
        for (int k = 0; k < n; k++) tick();
        m_ack = 1'b0;
    endtask

    initial begin
        int n_high;
        model_reset();
        reset   = 1'b0;
        i_req   = 1'b1;
        i_addr  = 13'h0100;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_be    = 4'hF;
        d_addr  = 13'h0040;
        d_wdata = 32'h0;
        m_rdata = 32'h0;
        m_ack   = 1'b0;

        // T1: reset held with both requests pending, then D wins first
        tick();
        tick();
        check("t1_rst_busy",    64'(busy),    64'd0);
        check("t1_rst_m_req",   64'(m_req),   64'd0);
        check("t1_rst_i_ready", 64'(i_ready), 64'd0);
        check("t1_rst_d_rdata", 64'(d_rdata), 64'd0);
        reset = 1'b1;
        tick();
        check("t1_d_first_addr", 64'(m_addr), 64'h0040);
        check("t1_d_first_req",  64'(m_req),  64'd1);
        settle(6);

        // T2: single fetch, ack on first m_req cycle
        i_req   = 1'b1;
        i_addr  = 13'h0100;
        m_rdata = 32'h8C220004;
        tick();
        check("t2_m_addr", 64'(m_addr), 64'h0100);
        check("t2_m_be",   64'(m_be),   64'hF);
        m_ack = 1'b1;
        tick();
        check("t2_i_ready", 64'(i_ready), 64'd1);
        check("t2_i_rdata", 64'(i_rdata), 64'h8C220004);
        i_req = 1'b0;
        m_ack = 1'b0;
        tick();
        check("t2_i_ready_drop", 64'(i_ready), 64'd0);
        settle(2);

        // T3: simultaneous store and fetch; D first, then I, no re-grant
        i_req   = 1'b1;
        i_addr  = 13'h0200;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_be    = 4'b0011;
        d_addr  = 13'h0080;
        d_wdata = 32'h1234ABCD;
        tick();
        check("t3_d_we",    64'(m_we),    64'd1);
        check("t3_d_be",    64'(m_be),    64'h3);
        check("t3_d_wdata", 64'(m_wdata), 64'h1234ABCD);
        m_ack   = 1'b1;
        m_rdata = 32'hDEADBEEF;
        tick();
        check("t3_d_ready",     64'(d_ready), 64'd1);
        check("t3_store_rdata", 64'(d_rdata), 64'd0);
        d_req = 1'b0;
        tick();
        check("t3_i_grant_addr", 64'(m_addr), 64'h0200);
        check("t3_i_grant_we",   64'(m_we),   64'd0);
        tick();
        check("t3_i_ready", 64'(i_ready), 64'd1);
        tick();
        check("t3_no_regrant", 64'(m_req), 64'd0);
        settle(2);

        // T5: hung load times out, then pending I is served normally
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 13'h0ABC;
        m_ack   = 1'b0;
        tick();
        i_req  = 1'b1;
        i_addr = 13'h0300;
        n_high = 1;
        while (m_req && n_high < 40) begin
            tick();
            if (m_req) n_high++;
        end
        check("t5_m_req_cycles", 64'(n_high), 64'(TIMEOUT));
        check("t5_d_ready", 64'(d_ready), 64'd1);
        check("t5_d_err",   64'(d_err),   64'd1);
        check("t5_d_rdata", 64'(d_rdata), 64'd0);
        d_req   = 1'b0;
        m_ack   = 1'b1;
        m_rdata = 32'h00C0FFEE;
        tick();
        check("t5_i_grant_addr", 64'(m_addr), 64'h0300);
        tick();
        check("t5_i_ready", 64'(i_ready), 64'd1);
        check("t5_i_err",   64'(i_err),   64'd0);
        check("t5_i_rdata", 64'(i_rdata), 64'h00C0FFEE);
        settle(2);

        // T6: reset during second BUSY_D cycle, late ack afterwards
        d_req = 1'b1;
        d_we  = 1'b0;
        m_ack = 1'b0;
        tick();
        tick();
        check("t6_busy_before", 64'(busy), 64'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        d_req = 1'b0;
        m_ack = 1'b1;
        tick();
        check("t6_no_d_ready", 64'(d_ready), 64'd0);
        check("t6_m_req",      64'(m_req),   64'd0);
        check("t6_busy",       64'(busy),    64'd0);
        settle(2);

        // Starvation pressure: D always asking, I drops only on D's ready cycle
        for (int c = 0; c < 600; c++) begin
            d_req   = 1'b1;
            d_we    = 1'($urandom_range(0, 1));
            d_be    = 4'($urandom);
            d_addr  = AW'($urandom);
            d_wdata = $urandom;
            i_req   = !mdl_d_ready;
            i_addr  = AW'($urandom);
            m_rdata = $urandom;
            m_ack   = ($urandom_range(0, 3) != 0);
            tick();
        end
        settle(4);

        // Fully random traffic with rare resets and periodic memory stalls
        for (int c = 0; c < 3000; c++) begin
            reset   = ($urandom_range(0, 149) != 0);
            i_req   = ($urandom_range(0, 3) != 0);
            i_addr  = AW'($urandom);
            d_req   = ($urandom_range(0, 3) != 0);
            d_we    = 1'($urandom_range(0, 1));
            d_be    = 4'($urandom);
            d_addr  = AW'($urandom);
            d_wdata = $urandom;
            m_rdata = $urandom;
            m_ack   = ((c % 500) >= 460) ? 1'b0 : ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
